// File: rtl/d3d_bit_serializer.sv
// Feeds the serial divisible-by-3 detector: one-word holding register plus shifter,
// one clear_n=0 cycle before each word, then WIDTH bits on digit (MSB or LSB first).
module d3d_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             digit,
  output logic             digit_valid,
  output logic             word_last,
  output logic             clear_n,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full, hold_full_nx;
  logic             accept, take_hold, bypass;
  logic             head_nx;

  assign in_ready = ~hold_full;
  assign accept   = in_valid & ~hold_full;
  assign busy     = (state != IDLE) | hold_full;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    shreg_nx  = shreg;
    take_hold = 1'b0;
    bypass    = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          state_nx  = CLEAR;
          shreg_nx  = hold_data;
          take_hold = 1'b1;
        end
      end
      CLEAR: begin
        state_nx = SHIFT;
        cnt_nx   = '0;
      end
      SHIFT: begin
        if (cnt == LAST) begin
          if (hold_full) begin
            state_nx  = CLEAR;
            shreg_nx  = hold_data;
            take_hold = 1'b1;
          end else if (accept) begin
            // A word arriving on the last bit skips the holding register so
            // the next CLEAR follows immediately.
            state_nx = CLEAR;
            shreg_nx = in_data;
            bypass   = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx   = cnt + 1'b1;
          shreg_nx = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
        end
      end
      default: state_nx = IDLE;
    endcase
    hold_full_nx = (hold_full & ~take_hold) | (accept & ~bypass);
    head_nx      = MSB_FIRST ? shreg_nx[WIDTH-1] : shreg_nx[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      digit       <= 1'b0;
      digit_valid <= 1'b0;
      word_last   <= 1'b0;
      clear_n     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      shreg     <= shreg_nx;
      hold_full <= hold_full_nx;
      if (accept & ~bypass) begin
        hold_data <= in_data;
      end
      // Outputs are registered from next-state so they line up with the state they describe.
      digit       <= (state_nx == SHIFT) & head_nx;
      digit_valid <= (state_nx == SHIFT);
      clear_n     <= (state_nx == SHIFT);
      word_last   <= (state_nx == SHIFT) && (cnt_nx == LAST);
    end
  end

endmodule
